// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits, even parity, 1 stop bit, 16x oversampling
// with a baud-selectable divider. Reports the byte plus parity/framing flags.
module uart_receiver (
   input  logic       clk,
   input  logic       reset,
   input  logic       RxD,
   input  logic [2:0] baud_select,
   input  logic       Rx_EN,
   output logic [7:0] Rx_DATA,
   output logic       Rx_VALID,
   output logic       Rx_PERROR,
   output logic       Rx_FERROR
);

   localparam int unsigned DIV_W  = 14;
   localparam int unsigned TICK_W = 4;
   localparam int unsigned BIT_W  = 3;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   logic              r_sync1;
   logic              r_sync2;
   logic              w_rxd;

   logic [DIV_W-1:0]  r_div;
   logic [2:0]        r_baud_q;
   logic [DIV_W-1:0]  w_tc;
   logic              w_div_restart;
   logic              w_tick;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [TICK_W-1:0] r_tick_cnt;
   logic [TICK_W-1:0] w_tick_nxt;
   logic [BIT_W-1:0]  r_bit_cnt;
   logic [BIT_W-1:0]  w_bit_nxt;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_shift_nxt;
   logic              r_par;
   logic              w_par_nxt;
   logic              r_armed;
   logic              w_armed_nxt;
   logic              w_mid;

   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] w_data_nxt;
   logic              r_perror;
   logic              w_perror_nxt;
   logic              r_ferror;
   logic              w_ferror_nxt;
   logic              r_valid;
   logic              w_valid_nxt;

   assign w_rxd     = r_sync2;
   assign Rx_DATA   = r_data;
   assign Rx_VALID  = r_valid;
   assign Rx_PERROR = r_perror;
   assign Rx_FERROR = r_ferror;

   // Two-flop synchronizer on the serial line, resets to the idle (high) level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= RxD;
         r_sync2 <= r_sync1;
      end
   end

   // Divider period in clk cycles for each baud setting (50 MHz / (16 * baud))
   always_comb begin
      w_tc = DIV_W'(27);
      case (baud_select)
         3'd0: w_tc = DIV_W'(10417);
         3'd1: w_tc = DIV_W'(2604);
         3'd2: w_tc = DIV_W'(651);
         3'd3: w_tc = DIV_W'(326);
         3'd4: w_tc = DIV_W'(163);
         3'd5: w_tc = DIV_W'(81);
         3'd6: w_tc = DIV_W'(54);
         3'd7: w_tc = DIV_W'(27);
         default: w_tc = DIV_W'(27);
      endcase
   end

   // Tick fires on the last count of each period; a baud change or disable restarts the count
   assign w_div_restart = !Rx_EN || (baud_select != r_baud_q);
   assign w_tick        = !w_div_restart && (r_div == (w_tc - DIV_W'(1)));

   // 16x-baud tick divider
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div    <= '0;
         r_baud_q <= '0;
      end else begin
         r_baud_q <= baud_select;
         if (w_div_restart || w_tick) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   assign w_mid = (r_tick_cnt == TICK_W'(15));

   // Receive FSM next-state and datapath/output next values
   always_comb begin
      w_state_nxt  = r_state;
      w_tick_nxt   = r_tick_cnt;
      w_bit_nxt    = r_bit_cnt;
      w_shift_nxt  = r_shift;
      w_par_nxt    = r_par;
      w_armed_nxt  = r_armed;
      w_data_nxt   = r_data;
      w_perror_nxt = r_perror;
      w_ferror_nxt = r_ferror;
      w_valid_nxt  = 1'b0;

      if (!Rx_EN) begin
         w_state_nxt = S_IDLE;
         w_tick_nxt  = '0;
         w_bit_nxt   = '0;
      end else if (w_tick) begin
         case (r_state)
            S_IDLE: begin
               // A line stuck low after a bad stop must be seen high before re-arming
               if (w_rxd) begin
                  w_armed_nxt = 1'b1;
               end else if (r_armed) begin
                  w_state_nxt = S_START;
                  w_tick_nxt  = '0;
               end
            end
            S_START: begin
               if (r_tick_cnt == TICK_W'(7)) begin
                  if (!w_rxd) begin
                     w_state_nxt = S_DATA;
                     w_tick_nxt  = '0;
                     w_bit_nxt   = '0;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_tick_nxt = r_tick_cnt + TICK_W'(1);
               end
            end
            S_DATA: begin
               w_tick_nxt = r_tick_cnt + TICK_W'(1);
               if (w_mid) begin
                  w_shift_nxt = {w_rxd, r_shift[DATA_W-1:1]};
                  w_bit_nxt   = r_bit_cnt + BIT_W'(1);
                  if (r_bit_cnt == BIT_W'(7)) begin
                     w_state_nxt = S_PARITY;
                  end
               end
            end
            S_PARITY: begin
               w_tick_nxt = r_tick_cnt + TICK_W'(1);
               if (w_mid) begin
                  w_par_nxt   = w_rxd;
                  w_state_nxt = S_STOP;
               end
            end
            S_STOP: begin
               w_tick_nxt = r_tick_cnt + TICK_W'(1);
               if (w_mid) begin
                  w_data_nxt   = r_shift;
                  w_perror_nxt = r_par ^ (^r_shift);
                  w_ferror_nxt = !w_rxd;
                  w_valid_nxt  = (r_par == (^r_shift)) && w_rxd;
                  w_armed_nxt  = w_rxd;
                  w_state_nxt  = S_IDLE;
                  w_tick_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_tick_nxt  = '0;
               w_bit_nxt   = '0;
            end
         endcase
      end
   end

   // FSM state, counters, datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_armed    <= 1'b1;
         r_data     <= '0;
         r_perror   <= 1'b0;
         r_ferror   <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tick_cnt <= w_tick_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_par      <= w_par_nxt;
         r_armed    <= w_armed_nxt;
         r_data     <= w_data_nxt;
         r_perror   <= w_perror_nxt;
         r_ferror   <= w_ferror_nxt;
         r_valid    <= w_valid_nxt;
      end
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  system clock, 50 MHz, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- RxD  input  1  serial line, idle high, asynchronous to clk
- baud_select  input  3  baud rate select, see REQ-005
- Rx_EN  input  1  receiver enable
- Rx_DATA  output  8  last received byte
- Rx_VALID  output  1  one-clk pulse, error-free byte available
- Rx_PERROR  output  1  parity error on last frame
- Rx_FERROR  output  1  framing error (stop bit = 0) on last frame

REQ-002 The block SHALL use exactly one clock, clk; there SHALL be no other clock domains and no derived clocks.

Function
REQ-003 The frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 parity bit equal to the XOR of the 8 data bits (even parity), and 1 stop bit (1).
REQ-004 RxD SHALL pass through a 2-flop synchronizer before use; all timing below refers to the synchronized signal.
REQ-005 An internal divider SHALL produce a one-clk tick at 16x baud, with terminal count by baud_select:
- 0: 10417 (300 baud)
- 1: 2604 (1200)
- 2: 651 (4800)
- 3: 326 (9600)
- 4: 163 (19200)
- 5: 81 (38400)
- 6: 54 (57600)
- 7: 27 (115200)
REQ-006 The divider SHALL restart at 0 whenever baud_select changes or Rx_EN is low.
REQ-007 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-008 IDLE: a synchronized RxD low sampled on a tick SHALL move the FSM to START and clear the 4-bit tick counter.
REQ-009 START: at tick count 7 (mid-bit), RxD low SHALL move the FSM to DATA; RxD high is a false start and SHALL return the FSM to IDLE with no output change.
REQ-010 DATA: RxD SHALL be sampled every 16 ticks at mid-bit into a shift register, LSB first; after the 8th sample the FSM SHALL move to PARITY.
REQ-011 PARITY: the mid-bit sample SHALL be stored; after it the FSM SHALL move to STOP.
REQ-012 STOP: on the mid-bit sample the FSM SHALL, in the same clk, load Rx_DATA with the shifted byte.
REQ-013 In that same clk, Rx_PERROR SHALL be set to (parity sample != XOR of the data bits).
REQ-014 In that same clk, Rx_FERROR SHALL be set to (stop sample == 0).
REQ-015 Rx_VALID SHALL pulse high for exactly one clk in that same clk only if both error flags are 0.
REQ-016 The FSM SHALL return to IDLE at the stop mid-bit so that a start bit immediately following the stop bit is detected (back-to-back frames).
REQ-017 Rx_DATA, Rx_PERROR and Rx_FERROR SHALL hold their values until the next STOP evaluation.
REQ-018 Rx_DATA SHALL be loaded even when a frame has errors.
REQ-019 When Rx_EN is low, the FSM SHALL be forced to IDLE and the tick and bit counters cleared, Rx_VALID SHALL be 0, and Rx_DATA and the error flags SHALL hold.
REQ-020 A frame in progress when Rx_EN falls SHALL be discarded.
REQ-021 A line held low continuously SHALL produce at most one frame (with FERROR=1); the FSM SHALL then re-arm only after RxD has been sampled high for at least one tick.

Reset
REQ-022 While reset is low, outputs SHALL be Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0 and Rx_FERROR=0.
REQ-023 While reset is low, the FSM SHALL be in IDLE, all counters SHALL be 0, and both synchronizer flops SHALL be 1.
REQ-024 Assertion of reset SHALL take effect immediately, including mid-frame, and abort any frame in progress.
REQ-025 After reset is released, the block SHALL detect the first start bit that begins at least 2 clk later.

Verification
REQ-026 The bench SHALL cover: baud_select=7, frame for 0xA5 with parity 0 and stop 1 -> Rx_DATA=0xA5, one Rx_VALID pulse, PERROR=0, FERROR=0.
REQ-027 The bench SHALL cover: baud_select=3, 0x3C with parity bit 1 -> Rx_DATA=0x3C, PERROR=1, no Rx_VALID.
REQ-028 The bench SHALL cover: baud_select=7, 0x81 with stop bit 0 -> FERROR=1, no Rx_VALID, followed by line high and a good 0x55 frame -> Rx_DATA=0x55, Rx_VALID, both flags 0.
REQ-029 The bench SHALL cover: RxD low glitch of 4 ticks -> no state change past START, no Rx_VALID, outputs unchanged.
REQ-030 The bench SHALL cover: back-to-back frames 0x00 then 0xFF with no idle gap -> two Rx_VALID pulses, Rx_DATA=0x00 then 0xFF.
REQ-031 The bench SHALL cover: reset asserted during data bit 4 of a frame -> outputs at reset values immediately, no Rx_VALID for that frame, and the next full frame 0x12 is received correctly.
